// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if: framebuffer read port.
// The address is registered by the engine; data returns one clock later.
interface vga_scan_engine_if #(
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0] vaddr;
  logic [31:0]       rdata;

  modport master (output vaddr, input rdata);
  modport slave  (input vaddr, output rdata);
endinterface

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised VGA timing, framebuffer fetch and unpack.
// Three register stages from the h/v counters to the pins.
module vga_scan_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int BPP         = 1,
  parameter int ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [11:0] FG = 12'hFFF,
  parameter logic [11:0] BG = 12'h000
) (
  input  logic             pixel_clk,
  input  logic             reset,
  vga_scan_engine_if.master fb,
  output logic [3:0]       VGA_R,
  output logic [3:0]       VGA_G,
  output logic [3:0]       VGA_B,
  output logic             VGA_HS_O,
  output logic             VGA_VS_O,
  output logic             de,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PPW     = 32 / BPP;
  localparam int PPW_SH  = (BPP == 1) ? 5 : 3;
  localparam int WPL     = (H_ACTIVE >> SCALE_SHIFT) / PPW;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] WPL_A = ADDR_W'(WPL);
  localparam logic [4:0] SEL_MASK = 5'(PPW - 1);

  if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0 ||
      (V_ACTIVE % (1 << SCALE_SHIFT)) != 0 ||
      (BPP != 1 && BPP != 4) ||
      ((H_ACTIVE >> SCALE_SHIFT) % PPW) != 0) begin : g_bad_cfg
    $error("vga_scan_engine: illegal geometry or BPP");
  end

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] lb_q, lb_d;
  logic              h_wrap, v_wrap, act0;

  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [4:0]        sel1_q, sel1_d, sel2_q;
  logic              act1_q, act2_q;
  logic              hs1_q, hs1_d, hs2_q;
  logic              vs1_q, vs1_d, vs2_q;
  logic              fs1_q, fs1_d, fs2_q;

  logic [11:0]       rgb_q, rgb_d;
  logic              de_q, hs_q, vs_q, fs_q;
  logic              pix1;
  logic [3:0]        pix4;

  always_comb begin
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    h_d     = h_wrap ? '0 : h_q + 1'b1;
    v_d     = v_q;
    lb_d    = lb_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
      // Advance once per logical row, on the last screen line it covers.
      if (v_wrap)
        lb_d = BASE_ADDR;
      else if (v_q < V_ACT && (v_q & V_MASK) == V_MASK)
        lb_d = lb_q + WPL_A;
    end
    act0    = (h_q < H_ACT) && (v_q < V_ACT);
    vaddr_d = act0
      ? lb_q + ADDR_W'(h_q >> (SCALE_SHIFT + PPW_SH))
      : lb_q;
    sel1_d  = 5'(h_q >> SCALE_SHIFT) & SEL_MASK;
    hs1_d   = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs1_d   = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
    fs1_d   = (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    pix1  = fb.rdata[sel2_q];
    pix4  = fb.rdata[{sel2_q[2:0], 2'b00} +: 4];
    rgb_d = '0;
    if (act2_q) begin
      if (BPP == 1)
        rgb_d = pix1 ? FG : BG;
      else
        rgb_d = {pix4, pix4, pix4};
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      lb_q    <= BASE_ADDR;
      vaddr_q <= BASE_ADDR;
      sel1_q  <= '0;
      act1_q  <= 1'b0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      fs1_q   <= 1'b0;
      sel2_q  <= '0;
      act2_q  <= 1'b0;
      hs2_q   <= ~HS_POL;
      vs2_q   <= ~VS_POL;
      fs2_q   <= 1'b0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      lb_q    <= lb_d;
      vaddr_q <= vaddr_d;
      sel1_q  <= sel1_d;
      act1_q  <= act0;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      sel2_q  <= sel1_q;
      act2_q  <= act1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      fs2_q   <= fs1_q;
      rgb_q   <= rgb_d;
      de_q    <= act2_q;
      hs_q    <= hs2_q;
      vs_q    <= vs2_q;
      fs_q    <= fs2_q;
    end
  end

  assign fb.vaddr    = vaddr_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS_O    = hs_q;
  assign VGA_VS_O    = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: directed checks of timing, addressing and unpack.
// Default horizontal timing, shortened vertical timing (16+2+2+2 lines).
module tb_vga_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst4_n;

  vga_scan_engine_if #(.ADDR_W(10)) fb1 ();
  vga_scan_engine_if #(.ADDR_W(10)) fb4 ();

  logic [3:0] r1, g1, b1, r4, g4, b4;
  logic hs1, vs1, de1, fs1;
  logic hs4, vs4, de4, fs4;

  vga_scan_engine #(
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2), .BPP(1)
  ) dut1 (
    .pixel_clk(clk), .reset(rst1_n), .fb(fb1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS_O(hs1), .VGA_VS_O(vs1),
    .de(de1), .frame_start(fs1)
  );

  vga_scan_engine #(
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2), .BPP(4)
  ) dut4 (
    .pixel_clk(clk), .reset(rst4_n), .fb(fb4),
    .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
    .VGA_HS_O(hs4), .VGA_VS_O(vs4),
    .de(de4), .frame_start(fs4)
  );

  // Registered framebuffers: even words 0x5, odd words all ones.
  always_ff @(posedge clk)
    fb1.rdata <= fb1.vaddr[0] ? 32'hFFFF_FFFF : 32'h0000_0005;
  always_ff @(posedge clk)
    fb4.rdata <= 32'h0000_00A3;

  int n_pass = 0;
  int n_chk  = 0;
  int pos    = 0;
  int hs_lo  = 0;
  int vs_lo  = 0;
  int de_n   = 0;
  int de_vb  = 0;
  int fs_x   = 0;
  int r4p    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic acc();
    if (pos < 17600) begin
      if (hs1 == 1'b0) hs_lo++;
      if (vs1 == 1'b0) vs_lo++;
      if (de1) de_n++;
      if (de1 && pos >= 12800) de_vb++;
      if (fs1 && pos > 0) fs_x++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    pos++;
    acc();
  endtask

  task automatic adv(input int t);
    while (pos < t) step();
  endtask

  initial begin
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_hs", 32'(hs1), 32'h1);
    chk("rst_vs", 32'(vs1), 32'h1);
    chk("rst_col", 32'({r1, g1, b1}), 32'h0);
    chk("rst_de", 32'(de1), 32'h0);
    chk("rst_fs", 32'(fs1), 32'h0);
    chk("rst_vaddr", 32'(fb1.vaddr), 32'h0);
    chk("rst4_col", 32'({r4, g4, b4}), 32'h0);
    chk("rst4_hs", 32'(hs4), 32'h1);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    @(negedge clk);
    chk("fs_t1", 32'(fs1), 32'h0);
    @(negedge clk);
    chk("fs_t2", 32'(fs1), 32'h0);
    @(negedge clk);
    chk("fs_t3", 32'(fs1), 32'h1);
    pos = 0;
    acc();
    chk("de_x0", 32'(de1), 32'h1);
    chk("c1_x0", 32'({r1, g1, b1}), 32'hFFF);
    chk("c4_x0", 32'({r4, g4, b4}), 32'h333);
    adv(3);
    chk("c1_x3", 32'({r1, g1, b1}), 32'hFFF);
    chk("c4_x3", 32'({r4, g4, b4}), 32'h333);
    adv(4);
    chk("c1_x4", 32'({r1, g1, b1}), 32'h000);
    chk("c4_x4", 32'({r4, g4, b4}), 32'hAAA);
    adv(7);
    chk("c1_x7", 32'({r1, g1, b1}), 32'h000);
    chk("c4_x7", 32'({r4, g4, b4}), 32'hAAA);
    adv(8);
    chk("c1_x8", 32'({r1, g1, b1}), 32'hFFF);
    chk("c4_x8", 32'({r4, g4, b4}), 32'h000);
    adv(11);
    chk("c1_x11", 32'({r1, g1, b1}), 32'hFFF);
    adv(12);
    chk("c1_x12", 32'({r1, g1, b1}), 32'h000);
    adv(125);
    chk("va_h127", 32'(fb1.vaddr), 32'd0);
    adv(126);
    chk("va_h128", 32'(fb1.vaddr), 32'd1);
    adv(127);
    chk("c1_x127", 32'({r1, g1, b1}), 32'h000);
    adv(128);
    chk("c1_x128", 32'({r1, g1, b1}), 32'hFFF);
    adv(253);
    chk("va_h255", 32'(fb1.vaddr), 32'd1);
    adv(254);
    chk("va_h256", 32'(fb1.vaddr), 32'd2);
    adv(637);
    chk("va_h639", 32'(fb1.vaddr), 32'd4);
    adv(638);
    chk("va_h640", 32'(fb1.vaddr), 32'd0);
    adv(639);
    chk("de_x639", 32'(de1), 32'h1);
    adv(640);
    chk("de_x640", 32'(de1), 32'h0);
    chk("c1_x640", 32'({r1, g1, b1}), 32'h000);
    adv(655);
    chk("hs_h655", 32'(hs1), 32'h1);
    adv(656);
    chk("hs_h656", 32'(hs1), 32'h0);
    adv(751);
    chk("hs_h751", 32'(hs1), 32'h0);
    adv(752);
    chk("hs_h752", 32'(hs1), 32'h1);
    adv(799);
    chk("de_x799", 32'(de1), 32'h0);
    adv(800);
    chk("de_l1", 32'(de1), 32'h1);
    chk("c1_l1", 32'({r1, g1, b1}), 32'hFFF);
    adv(1455);
    chk("hs_l1_655", 32'(hs1), 32'h1);
    adv(1456);
    chk("hs_l1_656", 32'(hs1), 32'h0);
    adv(1900);
    rst4_n = 1'b0;
    step();
    step();
    chk("mr_col", 32'({r4, g4, b4}), 32'h0);
    chk("mr_de", 32'(de4), 32'h0);
    chk("mr_hs", 32'(hs4), 32'h1);
    chk("mr_vs", 32'(vs4), 32'h1);
    chk("mr_fs", 32'(fs4), 32'h0);
    chk("mr_vaddr", 32'(fb4.vaddr), 32'h0);
    rst4_n = 1'b1;
    step();
    chk("mr_fs_t1", 32'(fs4), 32'h0);
    step();
    chk("mr_fs_t2", 32'(fs4), 32'h0);
    chk("mr_hs_t2", 32'(hs4), 32'h1);
    step();
    r4p = pos;
    chk("mr_fs_t3", 32'(fs4), 32'h1);
    chk("mr_de_t3", 32'(de4), 32'h1);
    chk("mr_c_x0", 32'({r4, g4, b4}), 32'h333);
    adv(r4p + 3);
    chk("mr_c_x3", 32'({r4, g4, b4}), 32'h333);
    adv(r4p + 4);
    chk("mr_c_x4", 32'({r4, g4, b4}), 32'hAAA);
    adv(r4p + 655);
    chk("mr_hs_655", 32'(hs4), 32'h1);
    adv(r4p + 656);
    chk("mr_hs_656", 32'(hs4), 32'h0);
    adv(3037);
    chk("va_l3_639", 32'(fb1.vaddr), 32'd4);
    adv(3198);
    chk("va_l4_0", 32'(fb1.vaddr), 32'd5);
    adv(3200);
    chk("c1_l4", 32'({r1, g1, b1}), 32'hFFF);
    adv(12637);
    chk("va_l15_639", 32'(fb1.vaddr), 32'd19);
    adv(12798);
    chk("va_l16_0", 32'(fb1.vaddr), 32'd20);
    adv(12800);
    chk("de_l16", 32'(de1), 32'h0);
    adv(14399);
    chk("vs_pre", 32'(vs1), 32'h1);
    adv(14400);
    chk("vs_first", 32'(vs1), 32'h0);
    adv(15999);
    chk("vs_last", 32'(vs1), 32'h0);
    adv(16000);
    chk("vs_post", 32'(vs1), 32'h1);
    adv(17598);
    chk("va_wrap", 32'(fb1.vaddr), 32'd0);
    adv(17600);
    chk("fs_next", 32'(fs1), 32'h1);
    chk("c1_next", 32'({r1, g1, b1}), 32'hFFF);
    chk("hs_lo_cnt", 32'(hs_lo), 32'd2112);
    chk("vs_lo_cnt", 32'(vs_lo), 32'd1600);
    chk("de_cnt", 32'(de_n), 32'd10240);
    chk("de_vblank", 32'(de_vb), 32'd0);
    chk("fs_extra", 32'(fs_x), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised successor to the single-mode VGA controller: generates VGA timing for any resolution and polarity, fetches pixels from a word-organised framebuffer over a registered read port, and unpacks 1- or 4-bit pixels with integer power-of-two upscaling. It sits in the pixel clock domain between the data-memory read port and the board's 4-bit-per-channel VGA pins. It replaces the fixed 640x480 monochrome path.

## Interface
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixel clocks.
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
- HS_POL 0, VS_POL 0: sync active level (0 = active-low).
- SCALE_SHIFT 2: each framebuffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- BPP 1: bits per framebuffer pixel, 1 or 4.
- ADDR_W 10: framebuffer word-address width.
- BASE_ADDR 0: word address of framebuffer pixel (0,0).
- FG 12'hFFF, BG 12'h000: {R,G,B} colours for BPP=1 values 1 and 0.
- pixel_clk  in  1  pixel clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-low reset.
- rdata  in  32  framebuffer word; valid the cycle after vaddr is presented.
- vaddr  out  ADDR_W  framebuffer word address, registered.
- VGA_R, VGA_G, VGA_B  out  4 each  colour, registered.
- VGA_HS_O, VGA_VS_O  out  1 each  syncs, registered.
- de  out  1  display enable, aligned with colour.
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the colour outputs.

## Operation
- Derived values: H_TOTAL = sum of the H parameters, V_TOTAL = sum of the V parameters, PPW = 32/BPP, WPL = (H_ACTIVE>>SCALE_SHIFT)/PPW.
- Elaboration error if H_ACTIVE or V_ACTIVE is not divisible by 2^SCALE_SHIFT, if WPL is not an integer, or if BPP is not 1 or 4.
- Counters: h runs 0..H_TOTAL-1. v increments when h wraps, and runs 0..V_TOTAL-1.
- Region rules: active when h<H_ACTIVE and v<V_ACTIVE. HS is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. VS is asserted for the analogous v range.
- Logical coordinates: xl = h>>SCALE_SHIFT, yl = v>>SCALE_SHIFT.
- line_base register: resets to BASE_ADDR and reloads BASE_ADDR when v wraps. It adds WPL when h wraps, v<V_ACTIVE, and the low SCALE_SHIFT bits of v are all 1.
- Address: while active, the registered address is line_base + xl/PPW. In blanking it is line_base.
- All address arithmetic is modulo 2^ADDR_W and wraps silently.
- Unpack: the pixel in the word is sel = xl mod PPW. Its value is rdata[BPP*sel +: BPP], LSB-first.
- BPP=1: value 1 gives FG, value 0 gives BG.
- BPP=4: value g drives g on all three channels (greyscale).
- Blanking (de=0) forces the colour outputs to 0.
- The same word is refetched for every screen pixel it covers. The block has no prefetch buffer.

## Timing
- Stage 0 (cycle t): h and v counters.
- Stage 1 (t+1): vaddr registered. sel, active, HS and VS are delayed in step.
- Stage 2 (t+2): rdata is valid and is used combinationally.
- Stage 3 (t+3): colour, de, syncs and frame_start are registered out. Total latency is 3 clocks from counter state to pins, identical for every output.
- Sync widths are exactly H_SYNC clocks and V_SYNC*H_TOTAL clocks.
- frame_start period: H_TOTAL*V_TOTAL clocks.
- Reset (reset=0 at a rising edge), regardless of current state: h=v=0, line_base=BASE_ADDR, vaddr=BASE_ADDR, colour=0, de=0, frame_start=0. Syncs go to their inactive level (~HS_POL, ~VS_POL) and all pipeline stages clear.
- First cycle after reset release: counters at (0,0). The first frame_start pulse occurs 3 clocks later.
- Mid-frame reset: same as above. There is no partial line or glitch pulse on the syncs after release.
- At a simultaneous h and v wrap (h=H_TOTAL-1, v=V_TOTAL-1), line_base reloads BASE_ADDR. The BASE_ADDR reload has priority over the WPL increment.

## Test plan
- Reset: hold reset=0 for 5 clocks, then release. Required: VGA_HS_O=VGA_VS_O=1, colour 0, de=0 and vaddr=0 during reset. frame_start pulses exactly 3 clocks after release.
- HS timing (defaults): VGA_HS_O is low for exactly 96 clocks, first low on the output 3 clocks after h=656. The HS period is 800 clocks. de is high for exactly 640 consecutive clocks per active line.
- Frame: the next frame_start follows 420000 clocks after the previous one. VS is low for exactly 1600 clocks. de is never high during vertical blanking.
- Addressing (defaults): in line v=0, vaddr holds 0 for 128 clocks, then 1..4 for 128 clocks each. Lines 1-3 repeat that sequence. Line 4 starts at address 5. Line 479 covers addresses 595..599.
- Unpack, BPP=1: rdata=32'h0000_0005 at every address. Each line starts with 4 FG pixels (F,F,F), 4 BG pixels (0,0,0), then 4 FG pixels. Pixels at x=12..127 are BG.
- BPP=4 variant: rdata=32'h0000_00A3. Colour is 3 on all channels for x=0..3 and 10 for x=4..7. A mid-line reset forces 0 outputs and a restart at (0,0).
